// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int REG_W = 5;
endpackage

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: saturating busy-cycle counter with sticky timeout flag
module hazard_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic mem_timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] MAX = W'(MEM_TIMEOUT);
  logic [W-1:0] cnt, nxt;
  always_comb nxt = start ? W'(1) : busy ? (cnt == MAX ? cnt : cnt + 1'b1) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cnt <= nxt;
      if (nxt == MAX) mem_timeout <= 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and mem-busy freeze for the 5-stage core
// HAZARD_STATS_EN adds stall_cnt / flush_cnt / memwait_cnt performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_IR1,
  input  logic [REG_W-1:0] rs2_IR1,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             MemRead_IR2,
  input  logic [REG_W-1:0] rd_IR2,
  input  logic             branch_taken_IR3,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ir1_write,
  output logic             pipe_en,
  output logic             ir2_bubble,
  output logic             ir1_flush,
  output logic             ir2_flush,
  output logic             ir3_flush,
  output logic             pc_sel_branch,
`ifdef HAZARD_STATS_EN
  output logic             mem_timeout,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      memwait_cnt
`else
  output logic             mem_timeout
`endif
);
  state_t state;
  logic load_use, hold, br, lu;
  always_comb begin
    load_use = MemRead_IR2 && rd_IR2 != '0 &&
               ((use_rs1 && rs1_IR1 == rd_IR2) || (use_rs2 && rs2_IR1 == rd_IR2));
    hold = reset || mem_busy;
    br = !hold && branch_taken_IR3;
    lu = !hold && !branch_taken_IR3 && load_use;
    pc_write = !hold && !lu;
    ir1_write = !hold && !lu;
    pipe_en = !hold;
    ir2_bubble = lu;
    ir1_flush = br;
    ir2_flush = br;
    ir3_flush = br;
    pc_sel_branch = br;
  end
  // outputs depend only on inputs; the state only steers the wait counter
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else state <= mem_busy ? MEM_WAIT : RUN;
  hazard_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(state == RUN && mem_busy),
    .busy(state == MEM_WAIT && mem_busy),
    .mem_timeout(mem_timeout)
  );
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      memwait_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(lu);
      flush_cnt <= flush_cnt + 32'(br);
      memwait_cnt <= memwait_cnt + 32'(state == MEM_WAIT);
    end
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. Detects load-use hazards between ID and EX, and generates stall, bubble and flush controls for the PC, IF/ID (IR1), ID/EX (IR2) and EX/MEM (IR3) registers. Freezes the whole pipeline while data memory reports busy, with a bounded-wait watchdog. Sits beside the ID stage; its outputs drive the PC register, IR1, IR2 and IR3.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive busy cycles before `mem_timeout` is raised; range 1..65535.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- rs1_IR1, rs2_IR1  in  5 each  source register fields of the instruction in ID.
- use_rs1, use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- MemRead_IR2  in  1  the instruction in EX is a load.
- rd_IR2  in  5  destination register of the instruction in EX.
- branch_taken_IR3  in  1  the branch in MEM resolved taken.
- mem_busy  in  1  data memory cannot complete this cycle.
- pc_write  out  1  PC load enable.
- ir1_write  out  1  IR1 load enable.
- pipe_en  out  1  load enable for IR2, IR3 and IR4.
- ir2_bubble  out  1  IR2 loads all-zero controls (RegWrite, MemRead, MemWrite, Branch = 0).
- ir1_flush, ir2_flush, ir3_flush  out  1 each  the register loads zero instead of its input.
- pc_sel_branch  out  1  PC mux selects the branch target.
- mem_timeout  out  1  sticky watchdog flag.

## Operation
- States: RUN, MEM_WAIT. The state is registered. All other outputs are combinational from state and inputs.
- load_use = MemRead_IR2 & (rd_IR2 != 0) & ((use_rs1 & rs1_IR1 == rd_IR2) | (use_rs2 & rs2_IR1 == rd_IR2)).
- Priority within a cycle: reset > mem_busy > branch_taken_IR3 > load_use > normal.
- Normal: pc_write = ir1_write = pipe_en = 1; all flush, bubble and select outputs = 0.
- RUN, mem_busy = 1:
  - pc_write = ir1_write = pipe_en = 0; flushes and bubble = 0.
  - Next state MEM_WAIT; wait counter loads 1.
- RUN, branch_taken_IR3 = 1 (not busy):
  - pc_sel_branch = 1 and pc_write = 1.
  - ir1_flush = ir2_flush = ir3_flush = 1.
  - load_use is ignored this cycle.
- RUN, load_use = 1 (not busy, no branch):
  - pc_write = ir1_write = 0; pipe_en = 1; ir2_bubble = 1.
  - The stall lasts exactly one cycle, because the bubble clears MemRead_IR2.
- MEM_WAIT: outputs as in the busy case.
  - While mem_busy = 1: the counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set. It stays set until reset.
  - When mem_busy = 0: next state RUN and counter clears. Outputs in that cycle follow the RUN rules (branch flush or load-use applies then).
- The branch stays in IR3 while the pipeline is held, so a branch coinciding with busy is never lost.
- Counter width: $clog2(MEM_TIMEOUT+1) bits, unsigned.

## Timing
- Reset values: state RUN, counter 0, mem_timeout 0.
- While reset is high: pc_write = ir1_write = pipe_en = 0 and all other outputs 0.
- Combinational latency is zero: stall, flush and bubble act at the same clock edge that would otherwise advance the hazard.
- Branch penalty: 3 flushed slots. Load-use penalty: 1 cycle.
- An N-cycle busy burst holds the pipeline for N cycles.
- mem_timeout asserts on the clock edge that ends the MEM_TIMEOUT-th consecutive busy cycle.
- Reset mid-wait returns to RUN immediately and clears mem_timeout and the counter.

## Configuration
- HAZARD_STATS_EN defined: adds three 32-bit wrapping output counters, all reset to 0:
  - stall_cnt: load-use cycles.
  - flush_cnt: taken-branch flush cycles.
  - memwait_cnt: cycles spent in MEM_WAIT.
- HAZARD_STATS_EN undefined: these ports and their registers are absent; behaviour is otherwise identical.

## Structure
- Shared package hazard_pkg holds the state enum (RUN, MEM_WAIT), the default MEM_TIMEOUT constant and the register-index width (5).
- One sub-module, hazard_wait_timer, holds the saturating counter and the sticky mem_timeout flag. It has inputs clk, reset, start, busy.
- Load-use compare and output decode stay in the top module.

## Test plan
- Load-use: MemRead_IR2 = 1, rd_IR2 = 5, rs1_IR1 = 5, use_rs1 = 1 -> one cycle with pc_write = 0, ir1_write = 0, ir2_bubble = 1. Next cycle (MemRead_IR2 = 0) is normal.
- x0 and unused operands: rd_IR2 = 0 matching rs1_IR1 = 0, or rs2 matching with use_rs2 = 0 -> no stall.
- Branch: branch_taken_IR3 = 1 in the same cycle as a load_use match -> pc_sel_branch = 1, all three flushes = 1, ir2_bubble = 0, pc_write = 1.
- Busy with branch: mem_busy = 1 for 4 cycles with branch_taken_IR3 = 1 throughout:
  - 4 cycles of all-enables-0 and no flush.
  - 5th cycle: flushes = 1 and pc_sel_branch = 1.
- Watchdog, MEM_TIMEOUT = 3: busy for 3 cycles -> mem_timeout = 1 after the 3rd edge and stays 1 after busy drops. Reset clears it.
- Reset mid-wait: assert reset asynchronously in cycle 2 of MEM_WAIT -> outputs go to reset values at once; state is RUN after release.
